frame_dispatcher: RTL and testbench

FRAME_DISPATCHER -- requirements
Module: frame_dispatcher

---
 rtl/frame_dispatcher_pkg.sv | 20 ++
 rtl/dispatch_period_tick.sv | 30 +++
 rtl/frame_dispatcher.sv | 188 ++++++++++++++++++
 tb/tb_frame_dispatcher.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_dispatcher_pkg.sv
// Shared configuration for the frame dispatcher: default sizing and FSM encodings.
package frame_dispatcher_pkg;

    // Default number of UART module channels.
    localparam int unsigned NUM_OF_MODULES = 9;
    // Default clk cycles between frame requests.
    localparam int unsigned TRIAG_T = 2400;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StRequest = 3'd1,
        StLatch   = 3'd2,
        StSend1   = 3'd3,
        StWait1   = 3'd4,
        StSend2   = 3'd5,
        StWait2   = 3'd6,
        StShoot   = 3'd7
    } state_e;

endpackage

// File: rtl/dispatch_period_tick.sv
// Free-running period counter; tick marks the last cycle of each period.
module dispatch_period_tick
    import frame_dispatcher_pkg::*;
#(
    parameter int unsigned PERIOD = TRIAG_T
) (
    input  logic clk,
    input  logic reset,
    input  logic enable_i,
    output logic tick_o
);

    localparam int unsigned CntW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CntW-1:0] cnt_q;
    logic            last;

    assign last   = (cnt_q == CntW'(PERIOD - 1));
    assign tick_o = enable_i && last;

    // Count 0..PERIOD-1 while enabled; parked at zero otherwise.
    always_ff @(posedge clk) begin
        if (reset || !enable_i || last) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/frame_dispatcher.sv
// Periodically requests an SPI sample and fans it out as two bytes to the
// selected UART channels, then fires a shoot pulse once the frame is complete.
module frame_dispatcher
    import frame_dispatcher_pkg::*;
#(
    parameter int unsigned NUM_CH    = NUM_OF_MODULES,
    parameter int unsigned PERIOD    = TRIAG_T,
    parameter int unsigned SHOOT_LEN = 48,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  mode,
    input  logic [NUM_CH-1:0]     ch_mask,
    output logic                  start_transfer,
    input  logic                  data_valid,
    input  logic [11:0]           sin_index,
    input  logic [3:0]            uart_id,
    output logic [NUM_CH-1:0]     start_tx,
    output logic [8*NUM_CH-1:0]   data_to_tx,
    input  logic [NUM_CH-1:0]     tx_busy,
    output logic                  shoot,
    output logic                  frame_drop,
    output logic                  overrun,
    output logic                  timeout_err
);

    // One counter serves both the wait-state timeout and the shoot width.
    localparam int unsigned CntMax = (TIMEOUT > SHOOT_LEN) ? TIMEOUT : SHOOT_LEN;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    state_e                state_q;
    logic [CntW-1:0]       cnt_q;
    logic [11:0]           sin_q;
    logic [3:0]            id_q;
    logic [NUM_CH-1:0]     active_q;
    logic [NUM_CH-1:0]     seen_q;
    logic [NUM_CH-1:0]     start_tx_q;
    logic [8*NUM_CH-1:0]   data_q;
    logic                  start_transfer_q;
    logic                  shoot_q;
    logic                  frame_drop_q;
    logic                  overrun_q;
    logic                  timeout_err_q;

    logic                  tick;
    logic [NUM_CH-1:0]     onehot;
    logic [NUM_CH-1:0]     latch_set;
    logic [NUM_CH-1:0]     seen_nxt;
    logic                  wait_clear;
    logic                  tmo_hit;
    logic                  shoot_done;

    dispatch_period_tick #(
        .PERIOD (PERIOD)
    ) u_tick (
        .clk      (clk),
        .reset    (reset),
        .enable_i (enable),
        .tick_o   (tick)
    );

    // Channel selection for the frame; ids beyond NUM_CH select nothing.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            onehot[i] = (int'(id_q) == i);
        end
        latch_set  = mode ? (onehot & ch_mask) : ch_mask;
        seen_nxt   = seen_q | (tx_busy & active_q);
        wait_clear = ((tx_busy & active_q) == '0);
        tmo_hit    = (cnt_q == CntW'(TIMEOUT - 1));
        shoot_done = (cnt_q == CntW'(SHOOT_LEN - 1));
    end

    // Frame sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= StIdle;
            cnt_q            <= '0;
            sin_q            <= '0;
            id_q             <= '0;
            active_q         <= '0;
            seen_q           <= '0;
            start_tx_q       <= '0;
            data_q           <= '0;
            start_transfer_q <= 1'b0;
            shoot_q          <= 1'b0;
            frame_drop_q     <= 1'b0;
            overrun_q        <= 1'b0;
            timeout_err_q    <= 1'b0;
        end else begin
            frame_drop_q <= 1'b0;
            cnt_q        <= cnt_q + CntW'(1);
            if (tick && (state_q != StIdle)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (tick) begin
                        start_transfer_q <= 1'b1;
                        cnt_q            <= '0;
                        state_q          <= StRequest;
                    end
                end
                StRequest: begin
                    if (data_valid) begin
                        sin_q            <= sin_index;
                        id_q             <= uart_id;
                        start_transfer_q <= 1'b0;
                        cnt_q            <= '0;
                        state_q          <= StLatch;
                    end else if (tmo_hit) begin
                        start_transfer_q <= 1'b0;
                        timeout_err_q    <= 1'b1;
                        state_q          <= StIdle;
                    end
                end
                StLatch: begin
                    if (latch_set == '0) begin
                        frame_drop_q <= 1'b1;
                        state_q      <= StIdle;
                    end else begin
                        active_q   <= latch_set;
                        seen_q     <= '0;
                        start_tx_q <= latch_set;
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (latch_set[i]) data_q[8*i +: 8] <= sin_q[11:4];
                        end
                        cnt_q   <= '0;
                        state_q <= StSend1;
                    end
                end
                StSend1, StSend2: begin
                    // Each start is released the cycle after its busy is seen.
                    seen_q     <= seen_nxt;
                    start_tx_q <= start_tx_q & ~(tx_busy & active_q);
                    if (seen_nxt == active_q) begin
                        start_tx_q <= '0;
                        cnt_q      <= '0;
                        state_q    <= (state_q == StSend1) ? StWait1 : StWait2;
                    end else if (tmo_hit) begin
                        start_tx_q    <= '0;
                        timeout_err_q <= 1'b1;
                        state_q       <= StIdle;
                    end
                end
                StWait1, StWait2: begin
                    if (wait_clear) begin
                        cnt_q <= '0;
                        if (state_q == StWait1) begin
                            for (int i = 0; i < NUM_CH; i++) begin
                                if (active_q[i]) data_q[8*i +: 8] <= {sin_q[3:0], id_q};
                            end
                            seen_q     <= '0;
                            start_tx_q <= active_q;
                            state_q    <= StSend2;
                        end else begin
                            shoot_q <= 1'b1;
                            state_q <= StShoot;
                        end
                    end else if (tmo_hit) begin
                        start_tx_q    <= '0;
                        timeout_err_q <= 1'b1;
                        state_q       <= StIdle;
                    end
                end
                StShoot: begin
                    if (shoot_done) begin
                        shoot_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign start_transfer = start_transfer_q;
    assign start_tx       = start_tx_q;
    assign data_to_tx     = data_q;
    assign shoot          = shoot_q;
    assign frame_drop     = frame_drop_q;
    assign overrun        = overrun_q;
    assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_frame_dispatcher.sv
// Directed bench for frame_dispatcher with a simple UART busy responder.
module tb_frame_dispatcher;

    localparam int NCH = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic              mode = 1'b0;
    logic [NCH-1:0]    ch_mask = '0;
    logic              start_transfer;
    logic              data_valid = 1'b0;
    logic [11:0]       sin_index = '0;
    logic [3:0]        uart_id = '0;
    logic [NCH-1:0]    start_tx;
    logic [8*NCH-1:0]  data_to_tx;
    logic [NCH-1:0]    tx_busy;
    logic              shoot;
    logic              frame_drop;
    logic              overrun;
    logic              timeout_err;

    logic [NCH-1:0]    force_busy = '0;
    logic [NCH-1:0]    st_prev = '0;
    int                busy_cnt[NCH] = '{default: 0};
    int                nsent[NCH] = '{default: 0};
    int                st_cycles[NCH] = '{default: 0};
    logic [15:0]       last2[NCH] = '{default: 16'h0};
    int                shoot_cycles = 0;
    int                drop_cycles = 0;

    int                checks = 0;
    int                failures = 0;

    frame_dispatcher #(
        .NUM_CH    (NCH),
        .PERIOD    (100),
        .SHOOT_LEN (48),
        .TIMEOUT   (4096)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .mode           (mode),
        .ch_mask        (ch_mask),
        .start_transfer (start_transfer),
        .data_valid     (data_valid),
        .sin_index      (sin_index),
        .uart_id        (uart_id),
        .start_tx       (start_tx),
        .data_to_tx     (data_to_tx),
        .tx_busy        (tx_busy),
        .shoot          (shoot),
        .frame_drop     (frame_drop),
        .overrun        (overrun),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    // UART responder: a rising start_tx makes the channel busy for 5 cycles.
    always_comb begin
        for (int i = 0; i < NCH; i++) tx_busy[i] = force_busy[i] | (busy_cnt[i] != 0);
    end

    always @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            st_prev[i] <= start_tx[i];
            if (start_tx[i]) st_cycles[i] <= st_cycles[i] + 1;
            if (busy_cnt[i] != 0) begin
                busy_cnt[i] <= busy_cnt[i] - 1;
            end else if (start_tx[i] && !st_prev[i]) begin
                busy_cnt[i] <= 5;
                nsent[i]    <= nsent[i] + 1;
                last2[i]    <= {last2[i][7:0], data_to_tx[8*i +: 8]};
            end
        end
        if (shoot) shoot_cycles <= shoot_cycles + 1;
        if (frame_drop) drop_cycles <= drop_cycles + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!start_transfer && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_start_transfer"}, 32'(start_transfer), 32'd1);
    endtask

    task automatic send_sample(input logic [11:0] s, input logic [3:0] id, input int delay);
        repeat (delay) @(negedge clk);
        sin_index  = s;
        uart_id    = id;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic measure_shoot(output int len);
        int n = 0;
        len = 0;
        while (!shoot && n < 2000) begin
            @(negedge clk);
            n++;
        end
        while (shoot && len < 500) begin
            @(negedge clk);
            len++;
        end
    endtask

    initial begin
        int len;
        int base_sent[NCH];
        int base_st[NCH];
        int base_shoot;
        int base_drop;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_start_transfer", 32'(start_transfer), 32'd0);
        check("rst_start_tx", 32'(start_tx), 32'd0);
        check("rst_data_to_tx", 32'(data_to_tx), 32'd0);
        check("rst_shoot", 32'(shoot), 32'd0);
        check("rst_frame_drop", 32'(frame_drop), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        reset = 1'b0;

        // Broadcast to all three channels
        mode = 1'b0;
        ch_mask = 3'b111;
        enable = 1'b1;
        wait_start("bc");
        enable = 1'b0;
        for (int i = 0; i < NCH; i++) base_sent[i] = nsent[i];
        send_sample(12'hABC, 4'h5, 2);
        measure_shoot(len);
        check("bc_shoot_len", 32'(len), 32'd48);
        for (int i = 0; i < NCH; i++) begin
            check($sformatf("bc_sent_ch%0d", i), 32'(nsent[i] - base_sent[i]), 32'd2);
            check($sformatf("bc_bytes_ch%0d", i), 32'(last2[i]), 32'h0000ABC5);
        end
        check("bc_data_to_tx", 32'(data_to_tx), 32'h00C5C5C5);
        check("bc_overrun", 32'(overrun), 32'd0);

        // Addressed to channel 2
        mode = 1'b1;
        enable = 1'b1;
        wait_start("addr");
        enable = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            base_sent[i] = nsent[i];
            base_st[i]   = st_cycles[i];
        end
        send_sample(12'h123, 4'h2, 3);
        measure_shoot(len);
        check("addr_shoot_len", 32'(len), 32'd48);
        check("addr_st_ch0", 32'(st_cycles[0] - base_st[0]), 32'd0);
        check("addr_st_ch1", 32'(st_cycles[1] - base_st[1]), 32'd0);
        check("addr_sent_ch2", 32'(nsent[2] - base_sent[2]), 32'd2);
        check("addr_bytes_ch2", 32'(last2[2]), 32'h00001232);
        check("addr_data_to_tx", 32'(data_to_tx), 32'h0032C5C5);

        // Out-of-range id drops the frame
        enable = 1'b1;
        wait_start("drop");
        enable = 1'b0;
        for (int i = 0; i < NCH; i++) base_st[i] = st_cycles[i];
        base_shoot = shoot_cycles;
        base_drop  = drop_cycles;
        send_sample(12'h456, 4'hA, 1);
        repeat (80) @(negedge clk);
        check("drop_pulse_cycles", 32'(drop_cycles - base_drop), 32'd1);
        check("drop_no_shoot", 32'(shoot_cycles - base_shoot), 32'd0);
        for (int i = 0; i < NCH; i++) begin
            check($sformatf("drop_st_ch%0d", i), 32'(st_cycles[i] - base_st[i]), 32'd0);
        end
        check("drop_data_held", 32'(data_to_tx), 32'h0032C5C5);

        // Channel 1 stuck busy: timeout in WAIT_1
        mode = 1'b0;
        force_busy = 3'b010;
        enable = 1'b1;
        wait_start("tmo");
        enable = 1'b0;
        base_shoot = shoot_cycles;
        send_sample(12'h789, 4'h1, 1);
        len = 0;
        while (!timeout_err && len < 6000) begin
            @(negedge clk);
            len++;
        end
        check("tmo_err", 32'(timeout_err), 32'd1);
        check("tmo_late_enough", 32'(len > 4000), 32'd1);
        check("tmo_start_tx", 32'(start_tx), 32'd0);
        check("tmo_start_transfer", 32'(start_transfer), 32'd0);
        check("tmo_data_to_tx", 32'(data_to_tx), 32'h00787878);
        repeat (60) @(negedge clk);
        check("tmo_no_shoot", 32'(shoot_cycles - base_shoot), 32'd0);
        check("tmo_err_sticky", 32'(timeout_err), 32'd1);
        force_busy = '0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("tmo_err_cleared", 32'(timeout_err), 32'd0);

        // Slow sample: a tick lands in REQUEST, frame still completes
        enable = 1'b1;
        wait_start("ovr");
        send_sample(12'hABC, 4'h5, 150);
        enable = 1'b0;
        check("ovr_overrun", 32'(overrun), 32'd1);
        measure_shoot(len);
        check("ovr_shoot_len", 32'(len), 32'd48);
        check("ovr_data_to_tx", 32'(data_to_tx), 32'h00C5C5C5);

        // Reset during the tenth shoot cycle
        enable = 1'b1;
        wait_start("rs");
        enable = 1'b0;
        send_sample(12'h0F0, 4'h3, 2);
        len = 0;
        while (!shoot && len < 2000) begin
            @(negedge clk);
            len++;
        end
        repeat (9) @(negedge clk);
        check("rs_shoot_before", 32'(shoot), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rs_shoot", 32'(shoot), 32'd0);
        check("rs_start_tx", 32'(start_tx), 32'd0);
        check("rs_data_to_tx", 32'(data_to_tx), 32'd0);
        check("rs_overrun", 32'(overrun), 32'd0);
        check("rs_start_transfer", 32'(start_transfer), 32'd0);
        reset = 1'b0;
        base_shoot = shoot_cycles;
        repeat (60) @(negedge clk);
        check("rs_no_partial_shoot", 32'(shoot_cycles - base_shoot), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
